// File: rtl/axi_write_arbiter.sv
// Purpose: single-transaction arbiter and route controller for the AXI write-path crossbar mux.
// Latency: the grant is registered 1 cycle after AWVALID in IDLE; the path is released on the edge of the B handshake.
// Backpressure: ungranted masters are routed to the idle dummy slave, which never asserts ready or BVALID, so they stall.
//
// Ports:
//   ACLK, ARESETn         clock, asynchronous active-low reset
//   AWVALID_M, AWADDR_M   per-master AW request and address (decoded only at grant time)
//   WVALID_M, WLAST_M     per-master W beat qualifiers
//   BREADY_M              per-master B ready
//   AWREADY_S, WREADY_S   per-slave ready signals; entry NUM_S is the default (decode-error) slave
//   BVALID_S              per-slave B valid, default slave included
//   SWIdx                 master routed to each slave (NUM_M = none)
//   MWIdx                 slave routed to each master (NUM_S+1 = idle dummy slave)
//   busy, grant_m         transaction in flight, granted master (NUM_M when idle)
module axi_write_arbiter #(
   parameter int NUM_M     = 3,
   parameter int NUM_S     = 6,
   parameter int MIDX_BITS = 2,
   parameter int SIDX_BITS = 3
) (
   input  logic                                ACLK,
   input  logic                                ARESETn,
   input  logic [NUM_M-1:0]                    AWVALID_M,
   input  logic [NUM_M-1:0][31:0]              AWADDR_M,
   input  logic [NUM_M-1:0]                    WVALID_M,
   input  logic [NUM_M-1:0]                    WLAST_M,
   input  logic [NUM_M-1:0]                    BREADY_M,
   input  logic [NUM_S:0]                      AWREADY_S,
   input  logic [NUM_S:0]                      WREADY_S,
   input  logic [NUM_S:0]                      BVALID_S,
   output logic [NUM_S:0][MIDX_BITS-1:0]       SWIdx,
   output logic [NUM_M-1:0][SIDX_BITS-1:0]     MWIdx,
   output logic                                busy,
   output logic [MIDX_BITS-1:0]                grant_m
);

   localparam logic [MIDX_BITS-1:0] M_IDLE = MIDX_BITS'(NUM_M);
   localparam logic [MIDX_BITS-1:0] M_LAST = MIDX_BITS'(NUM_M - 1);
   localparam logic [SIDX_BITS-1:0] S_DEF  = SIDX_BITS'(NUM_S);
   localparam logic [SIDX_BITS-1:0] S_IDLE = SIDX_BITS'(NUM_S + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Registered state
   state_t                 r_state;
   logic [MIDX_BITS-1:0]   r_grant_m;
   logic [SIDX_BITS-1:0]   r_gnt_s;
   logic [MIDX_BITS-1:0]   r_rr_ptr;
   logic                   r_aw_done;
   logic                   r_w_done;

   // Next-state values
   state_t                 w_state_nxt;
   logic [MIDX_BITS-1:0]   w_grant_nxt;
   logic [SIDX_BITS-1:0]   w_gnt_s_nxt;
   logic [MIDX_BITS-1:0]   w_rr_nxt;
   logic                   w_aw_nxt;
   logic                   w_w_nxt;

   // Arbitration
   logic                   w_req_vld;
   logic [MIDX_BITS-1:0]   w_req_m;
   logic [31:0]            w_req_addr;
   logic [SIDX_BITS-1:0]   w_req_s;
   int                     w_idx;

   // Handshake qualifiers on the locked path
   logic                   w_m_awvalid;
   logic                   w_m_wvalid;
   logic                   w_m_wlast;
   logic                   w_m_bready;
   logic                   w_s_awready;
   logic                   w_s_wready;
   logic                   w_s_bvalid;
   logic                   w_aw_hs;
   logic                   w_w_hs;
   logic                   w_b_hs;

   // Address map, inclusive ranges; holes fall through to the default slave.
   function automatic logic [SIDX_BITS-1:0] f_decode(input logic [31:0] a);
      logic [SIDX_BITS-1:0] s;
      s = S_DEF;
      if (a <= 32'h0000_3FFF)
         s = SIDX_BITS'(0);
      else if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF)
         s = SIDX_BITS'(1);
      else if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF)
         s = SIDX_BITS'(2);
      else if (a >= 32'h1002_0000 && a <= 32'h1002_03FF)
         s = SIDX_BITS'(3);
      else if (a >= 32'h1001_0000 && a <= 32'h1001_03FF)
         s = SIDX_BITS'(4);
      else if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF)
         s = SIDX_BITS'(5);
      return s;
   endfunction

   // Round-robin pick: first requester scanning from r_rr_ptr upward, wrapping at NUM_M.
   always_comb begin
      w_req_vld  = 1'b0;
      w_req_m    = M_IDLE;
      w_req_addr = '0;
      w_idx      = 0;
      for (int i = 0; i < NUM_M; i++) begin
         w_idx = (int'(r_rr_ptr) + i) % NUM_M;
         if (!w_req_vld && AWVALID_M[w_idx]) begin
            w_req_vld  = 1'b1;
            w_req_m    = MIDX_BITS'(w_idx);
            w_req_addr = AWADDR_M[w_idx];
         end
      end
   end

   assign w_req_s = f_decode(w_req_addr);

   // Select the granted master's and slave's handshake signals by compare rather than
   // direct indexing, so the idle index values never address past the vectors.
   always_comb begin
      w_m_awvalid = 1'b0;
      w_m_wvalid  = 1'b0;
      w_m_wlast   = 1'b0;
      w_m_bready  = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         if (r_grant_m == MIDX_BITS'(i)) begin
            w_m_awvalid = AWVALID_M[i];
            w_m_wvalid  = WVALID_M[i];
            w_m_wlast   = WLAST_M[i];
            w_m_bready  = BREADY_M[i];
         end
      end
   end

   always_comb begin
      w_s_awready = 1'b0;
      w_s_wready  = 1'b0;
      w_s_bvalid  = 1'b0;
      for (int j = 0; j <= NUM_S; j++) begin
         if (r_gnt_s == SIDX_BITS'(j)) begin
            w_s_awready = AWREADY_S[j];
            w_s_wready  = WREADY_S[j];
            w_s_bvalid  = BVALID_S[j];
         end
      end
   end

   assign w_aw_hs = w_m_awvalid & w_s_awready;
   assign w_w_hs  = w_m_wvalid & w_s_wready & w_m_wlast;
   assign w_b_hs  = w_s_bvalid & w_m_bready;

   // State register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state   <= ST_IDLE;
         r_grant_m <= M_IDLE;
         r_gnt_s   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant_m <= w_grant_nxt;
         r_gnt_s   <= w_gnt_s_nxt;
         r_rr_ptr  <= w_rr_nxt;
         r_aw_done <= w_aw_nxt;
         r_w_done  <= w_w_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant_m;
      w_gnt_s_nxt = r_gnt_s;
      w_rr_nxt    = r_rr_ptr;
      w_aw_nxt    = r_aw_done;
      w_w_nxt     = r_w_done;
      case (r_state)
         ST_IDLE: begin
            if (w_req_vld) begin
               w_state_nxt = ST_XFER;
               w_grant_nxt = w_req_m;
               w_gnt_s_nxt = w_req_s;
            end
         end
         ST_XFER: begin
            // AW and the last W beat may land in either order or together.
            w_aw_nxt = r_aw_done | w_aw_hs;
            w_w_nxt  = r_w_done | w_w_hs;
            if (w_aw_nxt && w_w_nxt)
               w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (w_b_hs) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = M_IDLE;
               w_gnt_s_nxt = S_IDLE;
               w_aw_nxt    = 1'b0;
               w_w_nxt     = 1'b0;
               // Pointer moves past the finished master only on completion.
               w_rr_nxt    = (r_grant_m == M_LAST) ? '0 : r_grant_m + MIDX_BITS'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = M_IDLE;
            w_gnt_s_nxt = S_IDLE;
            w_aw_nxt    = 1'b0;
            w_w_nxt     = 1'b0;
         end
      endcase
   end

   // Outputs depend on registered state only.
   assign busy    = (r_state != ST_IDLE);
   assign grant_m = r_grant_m;

   always_comb begin
      for (int j = 0; j <= NUM_S; j++)
         SWIdx[j] = (busy && r_gnt_s == SIDX_BITS'(j)) ? r_grant_m : M_IDLE;
      for (int i = 0; i < NUM_M; i++)
         MWIdx[i] = (busy && r_grant_m == MIDX_BITS'(i)) ? r_gnt_s : S_IDLE;
   end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Purpose: directed self-checking bench for axi_write_arbiter.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: slave readies and B valid are driven explicitly per step.
module tb_axi_write_arbiter;

   localparam int NUM_M = 3;
   localparam int NUM_S = 6;
   localparam int MIDX_BITS = 2;
   localparam int SIDX_BITS = 3;

   logic                               ACLK;
   logic                               ARESETn;
   logic [NUM_M-1:0]                   AWVALID_M;
   logic [NUM_M-1:0][31:0]             AWADDR_M;
   logic [NUM_M-1:0]                   WVALID_M;
   logic [NUM_M-1:0]                   WLAST_M;
   logic [NUM_M-1:0]                   BREADY_M;
   logic [NUM_S:0]                     AWREADY_S;
   logic [NUM_S:0]                     WREADY_S;
   logic [NUM_S:0]                     BVALID_S;
   logic [NUM_S:0][MIDX_BITS-1:0]      SWIdx;
   logic [NUM_M-1:0][SIDX_BITS-1:0]    MWIdx;
   logic                               busy;
   logic [MIDX_BITS-1:0]               grant_m;

   int n_vec = 0;
   int n_err = 0;

   axi_write_arbiter #(
      .NUM_M(NUM_M), .NUM_S(NUM_S), .MIDX_BITS(MIDX_BITS), .SIDX_BITS(SIDX_BITS)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWVALID_M(AWVALID_M), .AWADDR_M(AWADDR_M),
      .WVALID_M(WVALID_M), .WLAST_M(WLAST_M), .BREADY_M(BREADY_M),
      .AWREADY_S(AWREADY_S), .WREADY_S(WREADY_S), .BVALID_S(BVALID_S),
      .SWIdx(SWIdx), .MWIdx(MWIdx), .busy(busy), .grant_m(grant_m)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // Expected index arrays: everything idle except the one routed pair.
   function automatic logic [13:0] exp_sw(input int g, input int s);
      logic [13:0] v;
      v = 14'h3FFF;
      v[s*2 +: 2] = 2'(g);
      return v;
   endfunction

   function automatic logic [8:0] exp_mw(input int g, input int s);
      logic [8:0] v;
      v = 9'h1FF;
      v[g*3 +: 3] = 3'(s);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  32'(busy),    32'd0);
      chk({tag, "_grant"}, 32'(grant_m), 32'd3);
      chk({tag, "_swidx"}, 32'(SWIdx),   32'h3FFF);
      chk({tag, "_mwidx"}, 32'(MWIdx),   32'h1FF);
   endtask

   task automatic chk_path(input string tag, input int g, input int s);
      chk({tag, "_busy"},  32'(busy),    32'd1);
      chk({tag, "_grant"}, 32'(grant_m), 32'(g));
      chk({tag, "_swidx"}, 32'(SWIdx),   32'(exp_sw(g, s)));
      chk({tag, "_mwidx"}, 32'(MWIdx),   32'(exp_mw(g, s)));
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // AW and last W in one cycle, then a single B handshake.
   task automatic finish_txn(input string tag, input int g, input int s);
      AWVALID_M[g] = 1'b1; AWREADY_S[s] = 1'b1;
      WVALID_M[g]  = 1'b1; WLAST_M[g]   = 1'b1; WREADY_S[s] = 1'b1;
      step();
      AWVALID_M[g] = 1'b0; AWREADY_S[s] = 1'b0;
      WVALID_M[g]  = 1'b0; WLAST_M[g]   = 1'b0; WREADY_S[s] = 1'b0;
      chk_path({tag, "_resp"}, g, s);
      BVALID_S[s] = 1'b1; BREADY_M[g] = 1'b1;
      step();
      BVALID_S[s] = 1'b0; BREADY_M[g] = 1'b0;
      chk_idle({tag, "_done"});
   endtask

   initial begin
      ARESETn   = 1'b1;
      AWVALID_M = '0; AWADDR_M = '0; WVALID_M = '0; WLAST_M = '0; BREADY_M = '0;
      AWREADY_S = '0; WREADY_S = '0; BVALID_S = '0;

      // Reset values appear without a clock edge.
      #2 ARESETn = 1'b0;
      #1 chk_idle("reset");
      @(posedge ACLK);
      @(posedge ACLK);
      #3 ARESETn = 1'b1;
      step();

      // Single write: M1 -> DM, rr_ptr = 0.
      AWADDR_M[1] = 32'h0002_0010;
      AWVALID_M[1] = 1'b1;
      chk("single_no_comb_path", 32'(busy), 32'd0);
      step();
      chk_path("single_grant", 1, 2);
      finish_txn("single", 1, 2);

      // rr_ptr is now 2: M2 beats M0.
      AWADDR_M[0] = 32'h0000_0100;
      AWADDR_M[2] = 32'h1001_0000;
      AWVALID_M[0] = 1'b1; AWVALID_M[2] = 1'b1;
      step();
      chk_path("rr_after_m1", 2, 4);
      finish_txn("rr_m2", 2, 4);
      step();
      chk_path("rr_m0_next", 0, 0);
      finish_txn("rr_m0", 0, 0);

      // Contention from reset.
      #2 ARESETn = 1'b0;
      #2 ARESETn = 1'b1;
      step();
      AWADDR_M[0] = 32'h0000_3FFF;
      AWADDR_M[1] = 32'h0001_0000;
      AWADDR_M[2] = 32'h201F_FFFF;
      AWVALID_M = 3'b111;
      step();
      chk_path("cont_m0", 0, 0);
      finish_txn("cont_m0", 0, 0);
      step();
      chk_path("cont_m1", 1, 1);
      AWVALID_M[0] = 1'b1;
      finish_txn("cont_m1", 1, 1);
      step();
      chk_path("cont_m2", 2, 5);
      finish_txn("cont_m2", 2, 5);
      step();
      chk_path("cont_m0_again", 0, 0);
      finish_txn("cont_m0_again", 0, 0);

      // Decode error and range boundaries.
      AWADDR_M[2] = 32'h3000_0000;
      AWVALID_M[2] = 1'b1;
      step();
      chk_path("decerr", 2, 6);
      finish_txn("decerr", 2, 6);
      AWADDR_M[1] = 32'h1002_03FF;
      AWVALID_M[1] = 1'b1;
      step();
      chk_path("dma_top", 1, 3);
      finish_txn("dma_top", 1, 3);
      AWADDR_M[0] = 32'h0000_4000;
      AWVALID_M[0] = 1'b1;
      step();
      chk_path("rom_hole", 0, 6);
      finish_txn("rom_hole", 0, 6);

      // Burst with all W beats before AW; B held valid to catch an early release.
      AWADDR_M[0] = 32'h2000_0100;
      AWVALID_M[0] = 1'b1;
      step();
      chk_path("burst_grant", 0, 5);
      BVALID_S[5] = 1'b1; BREADY_M[0] = 1'b1;
      WVALID_M[0] = 1'b1; WREADY_S[5] = 1'b1;
      for (int b = 0; b < 4; b++) begin
         WLAST_M[0] = (b == 3);
         step();
         chk("burst_beat_busy", 32'(busy), 32'd1);
      end
      WVALID_M[0] = 1'b0; WLAST_M[0] = 1'b0; WREADY_S[5] = 1'b0;
      step();
      chk("burst_wait_aw_busy", 32'(busy), 32'd1);
      AWREADY_S[5] = 1'b1;
      step();
      AWVALID_M[0] = 1'b0; AWREADY_S[5] = 1'b0;
      chk_path("burst_resp", 0, 5);
      step();
      BVALID_S[5] = 1'b0; BREADY_M[0] = 1'b0;
      chk_idle("burst_done");

      // AW and last W together to IM; grant survives a dropped AWVALID.
      AWADDR_M[1] = 32'h0001_FFFF;
      AWVALID_M[1] = 1'b1;
      step();
      chk_path("same_grant", 1, 1);
      AWVALID_M[1] = 1'b0;
      step();
      chk_path("same_hold", 1, 1);
      finish_txn("same", 1, 1);

      // Reset mid-burst, then rr_ptr must be back at 0.
      AWADDR_M[2] = 32'h0002_0000;
      AWVALID_M[2] = 1'b1;
      step();
      chk_path("rst_grant", 2, 2);
      WVALID_M[2] = 1'b1; WREADY_S[2] = 1'b1;
      step();
      #2 ARESETn = 1'b0;
      #1 chk_idle("rst_async");
      AWVALID_M = '0; WVALID_M = '0; WREADY_S = '0;
      step();
      #2 ARESETn = 1'b1;
      step();
      AWADDR_M[0] = 32'h0000_0000;
      AWADDR_M[1] = 32'h0001_0000;
      AWADDR_M[2] = 32'h0002_0000;
      AWVALID_M = 3'b111;
      step();
      chk_path("rst_rr_zero", 0, 0);
      AWVALID_M[1] = 1'b0; AWVALID_M[2] = 1'b0;
      finish_txn("rst_after", 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
- Arbitration and routing control for the AXI write-path crossbar mux.
- Owns one write transaction (AW, W burst, B) at a time across all masters.
- Decodes the granted master's AWADDR to a slave and keeps the path locked until the B handshake.
- Drives the per-slave master-select (SWIdx) and per-master slave-select (MWIdx) index arrays consumed by the write mux.

Parameters:
NUM_M, 3, number of real masters; index NUM_M = idle dummy master
NUM_S, 6, number of real slaves; index NUM_S = default (decode-error) slave, NUM_S+1 = idle dummy slave
MIDX_BITS, 2, width of a master index
SIDX_BITS, 3, width of a slave index

Ports:
ACLK  input  1  clock
ARESETn  input  1  asynchronous active-low reset
AWVALID_M  input  NUM_M  AW valid per master
AWADDR_M  input  NUM_M x 32  AW address per master
WVALID_M  input  NUM_M  W valid per master
WLAST_M  input  NUM_M  W last per master
BREADY_M  input  NUM_M  B ready per master
AWREADY_S  input  NUM_S+1  AW ready per slave, including default slave
WREADY_S  input  NUM_S+1  W ready per slave, including default slave
BVALID_S  input  NUM_S+1  B valid per slave, including default slave
SWIdx  output  (NUM_S+1) x MIDX_BITS  master routed to each slave, entry NUM_S = default slave
MWIdx  output  NUM_M x SIDX_BITS  slave routed to each master
busy  output  1  transaction in flight
grant_m  output  MIDX_BITS  granted master, NUM_M when idle

Behaviour:
- Reset (async, ARESETn=0):
  - state=IDLE, rr_ptr=0, aw_done=0, w_done=0, busy=0, grant_m=NUM_M.
  - All SWIdx=NUM_M; all MWIdx=NUM_S+1.
  - Outputs take these values immediately, without waiting for a clock edge.
- Address decode (granted master's AWADDR, inclusive ranges):
  - S0 ROM 0x0000_0000–0x0000_3FFF
  - S1 IM 0x0001_0000–0x0001_FFFF
  - S2 DM 0x0002_0000–0x0002_FFFF
  - S3 DMA 0x1002_0000–0x1002_03FF
  - S4 WDT 0x1001_0000–0x1001_03FF
  - S5 DRAM 0x2000_0000–0x201F_FFFF
  - Anything else maps to NUM_S (default slave).
- States:
  - IDLE: if any AWVALID_M, pick the first requester scanning rr_ptr, rr_ptr+1, … mod NUM_M. On the clock edge, register grant_m and the decoded slave gnt_s, then go to XFER. Arbitration latency is exactly 1 cycle.
  - XFER: set aw_done on AWVALID_M[g] & AWREADY_S[gnt_s]. Set w_done on WVALID_M[g] & WREADY_S[gnt_s] & WLAST_M[g]. The two events may occur in either order or in the same cycle; W-before-AW is legal. Go to RESP on the edge where both flags are (or become) set.
  - RESP: on BVALID_S[gnt_s] & BREADY_M[g], go to IDLE, clear flags, set rr_ptr=(g+1) mod NUM_M, restore idle indices. A new grant may be issued no earlier than the cycle after return to IDLE.
- Outputs, driven combinationally from registered state only (no input-to-output path):
  - In XFER and RESP: SWIdx[gnt_s]=g, MWIdx[g]=gnt_s, busy=1.
  - All other SWIdx/MWIdx entries stay at their idle values.
- Decode is sampled only at grant time. AWADDR changes after grant are ignored (AXI stability is the master's responsibility).
- Masters not granted see the dummy slave (ready=0, BVALID=0) and therefore stall.
- Lower rr_ptr-relative index wins simultaneous requests. rr_ptr advances only on transaction completion, never on grant.
- A master that drops AWVALID after grant still keeps the grant until the full AW/W/B sequence completes. No timeout.
- Reset mid-transaction drops the grant immediately; the in-flight transfer is abandoned.

Test Plan:
- Single write: M1 writes 0x0002_0010 (DM), len 0, in IDLE with rr_ptr=0.
  -> Cycle+1: SWIdx[2]=1, MWIdx[1]=2, busy=1.
  -> After B handshake: SWIdx[2]=3, MWIdx[1]=7, rr_ptr=2.
- Contention: M0, M1 and M2 assert AWVALID in the same cycle from reset.
  -> Grant order M0, M1, M2; each grant waits for the prior B handshake.
  -> Re-requesting M0 then wins after M2.
- Decode error: M2 writes 0x3000_0000.
  -> SWIdx[6]=2, MWIdx[2]=6; completes via default slave BVALID.
- Burst with W first: M0 to DRAM 0x2000_0100, len 3.
  -> Four W beats (WLAST on 4th) precede the AW handshake.
  -> RESP entered only on the edge after AWREADY; no early return to IDLE.
- AW and last W in the same cycle to IM.
  -> Next cycle is RESP; a single B handshake returns to IDLE.
- Reset mid-burst: ARESETn low during XFER beat 2.
  -> busy=0, all SWIdx=3, all MWIdx=7 asynchronously.
  -> rr_ptr=0 after release.
